// File: rtl/seq_mult32.sv
// seq_mult32: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one add per cycle
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with a, b (multiplicand, multiplier);
//        out_valid/out_ready with product (2*WIDTH). Optional is_signed input when
//        SEQ_MULT_SIGNED_EN is defined (two's-complement operands, sampled at acceptance).
module bit32adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[32];
endmodule

module seq_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d, res;
  logic [WIDTH-1:0]   add_b, sum;
  logic               co;
`ifdef SEQ_MULT_SIGNED_EN
  logic               neg_q, neg_d;
`endif
  assign add_b = acc_lo_q[0] ? mcand_q : '0;
  if (WIDTH == 32) begin : g_rca
    bit32adder u_add (.a(acc_hi_q), .b(add_b), .cin(1'b0), .sum(sum), .cout(co));
  end else begin : g_beh
    assign {co, sum} = {1'b0, acc_hi_q} + {1'b0, add_b};
  end
  // carry-out becomes the new top bit so the accumulated product never overflows
  assign res = {co, sum, acc_lo_q[WIDTH-1:1]};
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = BUSY;
        acc_hi_d = '0;
        cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
        mcand_d  = (is_signed && a[WIDTH-1]) ? -a : a;
        acc_lo_d = (is_signed && b[WIDTH-1]) ? -b : b;
        neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
        mcand_d  = a;
        acc_lo_d = b;
`endif
      end
      BUSY: begin
        {acc_hi_d, acc_lo_d} = res;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef SEQ_MULT_SIGNED_EN
          product_d = neg_q ? -res : res;
`else
          product_d = res;
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign product   = product_q;
endmodule

// File: tb/tb_seq_mult32.sv
// tb_seq_mult32: scoreboard bench for seq_mult32
module tb_seq_mult32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] sb[$];
`ifdef SEQ_MULT_SIGNED_EN
  logic        is_signed = 1'b0;
  logic        sgn_mode = 1'b0;
`endif
  seq_mult32 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed(is_signed),
`endif
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic mul(input logic [31:0] x, input logic [31:0] y, input int hold, input logic [63:0] exp);
    int n;
    logic [63:0] e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a = x;
    b = y;
`ifdef SEQ_MULT_SIGNED_EN
    is_signed = sgn_mode;
`endif
    in_valid = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check("in_ready_busy", 64'(in_ready), 64'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    check("latency", 64'(n), 64'd32);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_hold", product, exp);
    end
    in_valid = 1'b0;
    e = sb.size() != 0 ? sb.pop_front() : ~exp;
    check("product", product, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_clr", 64'(out_valid), 64'd0);
    check("in_ready_back", 64'(in_ready), 64'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic [31:0] x, y;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mul(32'd3, 32'd5, 0, 64'h0000_0000_0000_000F);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001);
    mul(32'h1234_5678, 32'd0, 0, 64'd0);
    mul(32'd0, 32'h9ABC_DEF0, 0, 64'd0);
    mul(32'h0001_0000, 32'h0001_0000, 10, 64'h0000_0001_0000_0000);
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    in_valid = 1'b1;
    sb.push_back(64'({32'b0, a}) * 64'({32'b0, b}));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("abort_no_emit", 64'(n), 64'd0);
    mul(32'd7, 32'd9, 0, 64'd63);
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      mul(x, y, i, {32'b0, x} * {32'b0, y});
    end
`ifdef SEQ_MULT_SIGNED_EN
    sgn_mode = 1'b1;
    mul(32'hFFFF_FFFD, 32'd5, 0, 64'hFFFF_FFFF_FFFF_FFF1);
    mul(32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000);
    mul(32'h8000_0000, 32'd3, 0, 64'hFFFF_FFFE_8000_0000);
    sgn_mode = 1'b0;
    mul(32'hFFFF_FFFD, 32'd5, 0, 64'h0000_0004_FFFF_FFF1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
